// File: rtl/mem_arb_pkg.sv
// Shared constants for the data-RAM arbiter: default geometry and grant encoding.
package mem_arb_pkg;

  localparam int unsigned AW_DEF      = 16;
  localparam int unsigned DW_DEF      = 16;
  localparam int unsigned DEPTH_DEF   = 256;
  localparam int unsigned AGE_MAX_DEF = 3;
  localparam int unsigned AGE_W       = 4;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_age_ctr.sv
// Saturating wait counter for the instruction requester; at_max flags that I must win.
module mem_arb_age_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned AGE_MAX = AGE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [AGE_W-1:0] cnt_q;

  assign at_max = (cnt_q == AGE_W'(AGE_MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + AGE_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the single-port data RAM: D has priority,
// I is forced through after waiting AGE_MAX cycles; responses return one cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned AGE_MAX = AGE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic          i_rsp_valid,
  output logic [DW-1:0] i_rdata,
  output logic          i_rsp_err,
  input  logic          d_valid,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rdata,
  output logic          d_rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned    AW_EXT  = AW + 1;
  localparam logic [AW:0]    DEPTH_X = AW_EXT'(DEPTH);

  logic [1:0]    gnt;
  logic          age_at_max;
  logic          force_i;
  logic          i_acc;
  logic          d_acc;
  logic [AW-1:0] sel_addr;
  logic          sel_in_range;
  logic [DW-1:0] sel_rdata;
  logic          i_rsp_valid_q;
  logic          d_rsp_valid_q;

  assign force_i = i_valid && age_at_max;

  // Fixed D priority unless I has aged out
  always_comb begin
    gnt = GNT_NONE;
    if (force_i || (i_valid && !d_valid)) begin
      gnt = GNT_I;
    end else if (d_valid) begin
      gnt = GNT_D;
    end
  end

  assign i_ready = (gnt == GNT_I) && !rst;
  assign d_ready = (gnt == GNT_D) && !rst;
  assign i_acc   = i_valid && i_ready;
  assign d_acc   = d_valid && d_ready;

  always_comb begin
    sel_addr = '0;
    case (gnt)
      GNT_I:   sel_addr = i_addr;
      GNT_D:   sel_addr = d_addr;
      default: sel_addr = '0;
    endcase
  end

  assign sel_in_range = ({1'b0, sel_addr} < DEPTH_X);
  assign sel_rdata    = sel_in_range ? mem_rdata : '0;

  assign mem_addr  = sel_addr;
  assign mem_wdata = d_wdata;
  assign mem_we    = d_acc && d_we && sel_in_range;

  mem_arb_age_ctr #(
    .AGE_MAX (AGE_MAX)
  ) u_age_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (i_acc || !i_valid),
    .inc    (1'b1),
    .at_max (age_at_max)
  );

  // Response capture; the read port shows the pre-write word on a D write
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rsp_valid_q <= 1'b0;
      i_rdata       <= '0;
      i_rsp_err     <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rdata       <= '0;
      d_rsp_err     <= 1'b0;
    end else begin
      i_rsp_valid_q <= i_acc;
      d_rsp_valid_q <= d_acc;
      if (i_acc) begin
        i_rdata   <= sel_rdata;
        i_rsp_err <= !sel_in_range;
      end
      if (d_acc) begin
        d_rdata   <= sel_rdata;
        d_rsp_err <= !sel_in_range;
      end
    end
  end

  // A response pending when reset rises is dropped in that same cycle
  assign i_rsp_valid = i_rsp_valid_q && !rst;
  assign d_rsp_valid = d_rsp_valid_q && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int AGE_MAX = 3;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [15:0] i_addr;
  logic        i_ready;
  logic        i_rsp_valid;
  logic [15:0] i_rdata;
  logic        i_rsp_err;
  logic        d_valid;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic        d_rsp_valid;
  logic [15:0] d_rdata;
  logic        d_rsp_err;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] ram     [0:255];
  logic [15:0] ref_mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the pending responses and how long I has been waiting
  int          i_wait;
  bit          known;
  logic        exp_iv, exp_dv, exp_ie, exp_de;
  logic [15:0] exp_ird, exp_drd;
  logic        last_gi, last_gd;
  logic        obs_i, obs_d, obs_drv;

  mem_arbiter #(
    .AW(16), .DW(16), .DEPTH(256), .AGE_MAX(AGE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
    .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata), .i_rsp_err(i_rsp_err),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_rsp_err(d_rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM behind the arbiter; out-of-range reads return junk the DUT must hide
  assign mem_rdata = (mem_addr < 16'd256) ? ram[mem_addr[7:0]] : 16'hDEAD;
  always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)     return 16'($urandom);
    else if (r < 8) return 16'($urandom_range(0, 7));
    else            return 16'($urandom_range(0, 255));
  endfunction

  // Called just after a negedge with inputs set; compares, advances the model, returns at next negedge
  task automatic cycle();
    logic gi, gd, ir, dr, we_e;
    #1;
    gi   = !rst && i_valid && ((i_wait >= AGE_MAX) || !d_valid);
    gd   = !rst && d_valid && !gi;
    ir   = (i_addr < 16'd256);
    dr   = (d_addr < 16'd256);
    we_e = gd && d_we && dr;

    check("i_ready", 32'(i_ready), 32'(gi));
    check("d_ready", 32'(d_ready), 32'(gd));
    check("mem_we", 32'(mem_we), 32'(we_e));
    check("mem_wdata", 32'(mem_wdata), 32'(d_wdata));
    if (gi)      check("mem_addr_i", 32'(mem_addr), 32'(i_addr));
    else if (gd) check("mem_addr_d", 32'(mem_addr), 32'(d_addr));
    else if (!rst && !i_valid && !d_valid) check("mem_addr_idle", 32'(mem_addr), 32'(0));
    check("i_rsp_valid", 32'(i_rsp_valid), 32'(exp_iv && !rst));
    check("d_rsp_valid", 32'(d_rsp_valid), 32'(exp_dv && !rst));
    if (known) begin
      check("i_rdata", 32'(i_rdata), 32'(exp_ird));
      check("i_rsp_err", 32'(i_rsp_err), 32'(exp_ie));
      check("d_rdata", 32'(d_rdata), 32'(exp_drd));
      check("d_rsp_err", 32'(d_rsp_err), 32'(exp_de));
    end
    obs_i   = i_ready;
    obs_d   = d_ready;
    obs_drv = d_rsp_valid;

    if (rst) begin
      exp_iv = 0; exp_dv = 0; exp_ie = 0; exp_de = 0;
      exp_ird = '0; exp_drd = '0;
      i_wait = 0;
      known  = 1;
    end else begin
      exp_iv = gi;
      exp_dv = gd;
      if (gi) begin
        exp_ird = ir ? ref_mem[i_addr[7:0]] : 16'h0000;
        exp_ie  = !ir;
      end
      if (gd) begin
        exp_drd = dr ? ref_mem[d_addr[7:0]] : 16'h0000;
        exp_de  = !dr;
        if (we_e) ref_mem[d_addr[7:0]] = d_wdata;
      end
      if (!i_valid || gi)         i_wait = 0;
      else if (i_wait < AGE_MAX)  i_wait++;
    end
    last_gi = gi;
    last_gd = gd;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] old, w0;
    for (int k = 0; k < 256; k++) begin
      ram[k]     = 16'($urandom);
      ref_mem[k] = ram[k];
    end
    i_wait = 0; known = 0;
    exp_iv = 0; exp_dv = 0; exp_ie = 0; exp_de = 0; exp_ird = '0; exp_drd = '0;
    last_gi = 0; last_gd = 0;
    rst = 1; i_valid = 0; i_addr = '0; d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    @(negedge clk);

    // Reset holds off both requesters
    i_valid = 1; i_addr = 16'h0005; d_valid = 1; d_addr = 16'h0006;
    cycle();
    cycle();
    check("t1_i_ready", 32'(obs_i), 32'(0));
    check("t1_d_ready", 32'(obs_d), 32'(0));
    rst = 0; i_valid = 0; d_valid = 0;
    cycle();
    check("t1_rsp_idle", 32'({i_rsp_valid, d_rsp_valid}), 32'(0));

    // Write then read back through I
    d_valid = 1; d_we = 1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
    old = ref_mem[16];
    cycle();
    check("t2_wr_ack", 32'(d_rsp_valid), 32'(1));
    check("t2_old", 32'(d_rdata), 32'(old));
    d_valid = 0; d_we = 0; i_valid = 1; i_addr = 16'h0010;
    cycle();
    check("t2_rd_valid", 32'(i_rsp_valid), 32'(1));
    check("t2_rd", 32'(i_rdata), 32'(16'hBEEF));
    i_valid = 0;
    cycle();

    // Simultaneous requests: D first, I once D drops
    i_valid = 1; i_addr = 16'h0020; d_valid = 1; d_we = 0; d_addr = 16'h0021;
    cycle();
    check("t3_d_first", 32'(obs_d), 32'(1));
    check("t3_i_wait", 32'(obs_i), 32'(0));
    d_valid = 0;
    cycle();
    check("t3_i_next", 32'(obs_i), 32'(1));
    i_valid = 0;
    cycle();

    // Starvation guard: D,D,D,I repeating
    i_valid = 1; i_addr = 16'h0040; d_valid = 1; d_we = 0; d_addr = 16'h0041;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("t4_grant_d", 32'(obs_d), 32'((k % 4) != 3));
      check("t4_grant_i", 32'(obs_i), 32'((k % 4) == 3));
    end
    i_valid = 0; d_valid = 0;
    cycle();

    // Out-of-range write and read
    w0 = ram[0];
    d_valid = 1; d_we = 1; d_addr = 16'h0100; d_wdata = 16'hAAAA;
    cycle();
    check("t5_wr_err", 32'(d_rsp_err), 32'(1));
    check("t5_wr_rdata", 32'(d_rdata), 32'(0));
    d_we = 0;
    cycle();
    check("t5_rd_err", 32'(d_rsp_err), 32'(1));
    check("t5_rd_rdata", 32'(d_rdata), 32'(0));
    d_valid = 0;
    cycle();
    check("t5_ram0", 32'(ram[0]), 32'(w0));

    // Reset right after a D read acceptance, with I partially aged
    i_valid = 1; i_addr = 16'h0050; d_valid = 1; d_we = 0; d_addr = 16'h0030;
    cycle();
    cycle();
    rst = 1;
    cycle();
    check("t6_drop", 32'(obs_drv), 32'(0));
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t6_age_clr", 32'(obs_d), 32'(k != 3));
    end
    i_valid = 0; d_valid = 0;
    cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!i_valid || last_gi) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_addr  = rand_addr();
      end
      if (!d_valid || last_gd) begin
        d_valid = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = rand_addr();
        d_wdata = 16'($urandom);
      end
      cycle();
    end
    rst = 0; i_valid = 0; d_valid = 0;
    cycle();

    for (int k = 0; k < 256; k++) check("ram_word", 32'(ram[k]), 32'(ref_mem[k]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
